// File: rtl/p405s_exe_pkg.sv
// p405s_exe_pkg: shared types and state encoding for the logical-unit writeback stage
package p405s_exe_pkg;
  localparam int RT_W  = 5;
  localparam int CNT_W = 7;
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b10;
  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } skid_state_e;
  typedef struct packed {
    logic [0:31]     data;
    logic [RT_W-1:0] rt;
    logic [0:3]      cr0;
    logic            rc;
    logic            dlmzb;
  } wb_entry_t;
endpackage

// File: rtl/p405s_logical_wb_stage_if.sv
// p405s_logical_wb_stage_if: EXE-side capture and writeback-side handshake signals
interface p405s_logical_wb_stage_if;
  import p405s_exe_pkg::*;
  logic             exeValid;
  logic             exeReady;
  logic [0:31]      logicalOut;
  logic [0:2]       logicalCcBits;
  logic             dlmzb;
  logic             exeRc;
  logic [RT_W-1:0]  exeRt;
  logic             xerSO;
  logic             exeFlush;
  logic             wbValid;
  logic             wbReady;
  logic [0:31]      wbData;
  logic [RT_W-1:0]  wbRt;
  logic             wbCr0We;
  logic [0:3]       wbCr0;
  logic             wbXerCntWe;
  logic [CNT_W-1:0] wbXerCnt;
  modport slave (
    input  exeValid, logicalOut, logicalCcBits, dlmzb, exeRc, exeRt, xerSO, exeFlush, wbReady,
    output exeReady, wbValid, wbData, wbRt, wbCr0We, wbCr0, wbXerCntWe, wbXerCnt
  );
  modport master (
    output exeValid, logicalOut, logicalCcBits, dlmzb, exeRc, exeRt, xerSO, exeFlush, wbReady,
    input  exeReady, wbValid, wbData, wbRt, wbCr0We, wbCr0, wbXerCntWe, wbXerCnt
  );
endinterface

// File: rtl/p405s_skid2.sv
// p405s_skid2: two-entry skid buffer (head + skid) with flush, strict FIFO order
module p405s_skid2
  import p405s_exe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      flush_i,
  input  wb_entry_t din_i,
  output logic      ready_o,
  output logic      valid_o,
  output wb_entry_t dout_o
);
  skid_state_e state_q, state_d;
  wb_entry_t   head_q, head_d, skid_q, skid_d;
  logic        push, pop;
  assign ready_o = state_q != S_TWO;
  assign valid_o = state_q != S_EMPTY;
  assign dout_o  = head_q;
  assign push    = push_i & ready_o & ~flush_i;
  assign pop     = pop_i & valid_o;
  // next state and entry movement; flush clears everything back to the reset image
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: if (push) begin
        head_d  = din_i;
        state_d = S_ONE;
      end
      S_ONE: begin
        if (push && !pop) begin
          skid_d  = din_i;
          state_d = S_TWO;
        end else if (push && pop) head_d = din_i;
        else if (pop) begin
          head_d  = '0;
          state_d = S_EMPTY;
        end
      end
      S_TWO: if (pop) begin
        head_d  = skid_q;
        skid_d  = '0;
        state_d = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush_i) begin
      state_d = S_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end
  end
  // state and entry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: rtl/p405s_logical_wb_stage.sv
// p405s_logical_wb_stage: captures logical results with CR0/XER info and feeds writeback via a skid buffer
module p405s_logical_wb_stage
  import p405s_exe_pkg::*;
(
  input logic                      CB,
  input logic                      resetCore,
  p405s_logical_wb_stage_if.slave  wb
);
  wb_entry_t din, head;
  logic      valid;
  assign din = '{
    data:  wb.logicalOut,
    rt:    wb.exeRt,
    cr0:   {wb.logicalCcBits, wb.xerSO},
    rc:    wb.exeRc,
    dlmzb: wb.dlmzb
  };
  p405s_skid2 u_skid (
    .clk     (CB),
    .rst     (resetCore),
    .push_i  (wb.exeValid),
    .pop_i   (wb.wbReady),
    .flush_i (wb.exeFlush),
    .din_i   (din),
    .ready_o (wb.exeReady),
    .valid_o (valid),
    .dout_o  (head)
  );
  assign wb.wbValid    = valid;
  assign wb.wbData     = head.data;
  assign wb.wbRt       = head.rt;
  assign wb.wbCr0      = head.cr0;
  assign wb.wbCr0We    = valid & head.rc;
  assign wb.wbXerCntWe = valid & head.dlmzb;
  assign wb.wbXerCnt   = head.data[25:31];
endmodule
